// File: rtl/smd_pkg.sv
// Shared definitions for the Mega Drive pad emulator: button bit positions,
// phase encodings, idle pin pattern and the pin output multiplexer.
package smd_pkg;

  localparam int BTN_W = 12;
  localparam int PIN_W = 6;
  localparam int PH_W  = 2;

  // Bit positions inside one port's active-low button word
  localparam int BTN_UP = 0;
  localparam int BTN_DW = 1;
  localparam int BTN_LF = 2;
  localparam int BTN_RG = 3;
  localparam int BTN_A  = 4;
  localparam int BTN_B  = 5;
  localparam int BTN_C  = 6;
  localparam int BTN_ST = 7;
  localparam int BTN_X  = 8;
  localparam int BTN_Y  = 9;
  localparam int BTN_Z  = 10;
  localparam int BTN_MD = 11;

  // TH-rise count since the last timeout
  localparam logic [PH_W-1:0] PH_0 = 2'd0;
  localparam logic [PH_W-1:0] PH_1 = 2'd1;
  localparam logic [PH_W-1:0] PH_2 = 2'd2;
  localparam logic [PH_W-1:0] PH_3 = 2'd3;

  typedef logic [PIN_W-1:0] pins_t;

  // All data pins released (pulled high)
  localparam pins_t PIN_IDLE = 6'b111111;

  // Pin pattern {pin1,pin2,pin3,pin4,pin6,pin9} for a given phase and TH level.
  // Phase 2 with TH low is the all-low ID that marks a 6-button pad; phase 3
  // exposes the extra buttons while TH is high.
  function automatic pins_t pad_mux(input logic [PH_W-1:0] ph,
                                    input logic th_s,
                                    input logic [BTN_W-1:0] b);
    pins_t pins;
    pins = {b[BTN_UP], b[BTN_DW], b[BTN_LF], b[BTN_RG], b[BTN_B], b[BTN_C]};
    case (ph)
      PH_3: begin
        if (th_s) pins = {b[BTN_Z], b[BTN_Y], b[BTN_X], b[BTN_MD], 2'b11};
        else      pins = {4'b1111, b[BTN_A], b[BTN_ST]};
      end
      PH_2: begin
        if (!th_s) pins = {4'b0000, b[BTN_A], b[BTN_ST]};
      end
      default: begin
        if (!th_s) pins = {b[BTN_UP], b[BTN_DW], 2'b00, b[BTN_A], b[BTN_ST]};
      end
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/smd_pad_channel.sv
// One console port: TH synchronizer, idle timer, TH-rise phase counter,
// 3/6-button mode latch and the registered pin driver.
module smd_pad_channel
  import smd_pkg::*;
#(
  parameter int TIMEOUT     = 16000,
  parameter int CNT_W       = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             th,
  input  logic [BTN_W-1:0] btn,
  input  logic             force_three,
  output logic [PIN_W-1:0] p,
  output logic [PH_W-1:0]  phase,
  output logic             three_mode
);

  localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       timer;
  logic                   th_s;
  logic                   rise;
  pins_t                  pin_next;

  assign th_s = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-2] & ~th_s;

  // Synchronizer preset high so a TH already high at reset release is no rise
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], th};
  end

  // Mode is re-evaluated on every reset cycle and frozen afterwards
  always_ff @(posedge clk) begin
    if (rst) three_mode <= force_three | ~btn[BTN_MD];
  end

  // Phase counter with idle timeout; the timeout wins over a coincident rise
  always_ff @(posedge clk) begin
    if (rst || three_mode) begin
      phase <= PH_0;
      timer <= TIMER_LOAD;
    end else if (timer == '0) begin
      phase <= PH_0;
      timer <= TIMER_LOAD;
    end else if (rise) begin
      phase <= phase + 2'd1;
      timer <= TIMER_LOAD;
    end else begin
      timer <= timer - 1'b1;
    end
  end

  // Pin pattern selected from the current phase and synchronized TH
  always_comb begin
    pin_next = pad_mux(phase, th_s, btn);
  end

  // Registered pin drive, idle-high during reset
  always_ff @(posedge clk) begin
    if (rst) p <= PIN_IDLE;
    else     p <= pin_next;
  end

endmodule

// File: rtl/smd_multipad_out.sv
// Multi-port Mega Drive pad emulator: one independent channel per console
// port, with the flat buses sliced per port.
module smd_multipad_out
  import smd_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int TIMEOUT     = 16000,
  parameter int CNT_W       = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS-1:0]       th,
  input  logic [NPORTS*BTN_W-1:0] btn,
  input  logic [NPORTS-1:0]       force_three,
  output logic [NPORTS*PIN_W-1:0] p,
  output logic [NPORTS*PH_W-1:0]  phase,
  output logic [NPORTS-1:0]       three_mode
);

  // One channel per port; ports share only clock and reset
  for (genvar k = 0; k < NPORTS; k++) begin : g_port
    smd_pad_channel #(
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .th         (th[k]),
      .btn        (btn[k*BTN_W +: BTN_W]),
      .force_three(force_three[k]),
      .p          (p[k*PIN_W +: PIN_W]),
      .phase      (phase[k*PH_W +: PH_W]),
      .three_mode (three_mode[k])
    );
  end

endmodule
